// File: rtl/if_prefetch_pkg.sv
// Shared types and widths for the instruction prefetch unit.
package if_prefetch_pkg;

    localparam int unsigned PC_W          = 8;
    localparam int unsigned INST_W        = 8;
    localparam int unsigned DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } pf_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Show-ahead instruction queue of {pc, inst} entries with synchronous clear.
module prefetch_fifo
    import if_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Clear wins over any same-cycle push or pop.
    assign do_push = push && !clear;
    assign do_pop  = pop && !clear && (count != '0);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: one outstanding fetch at a time feeding a show-ahead queue.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int unsigned      DEPTH    = DEPTH_DEFAULT,
    parameter logic [PC_W-1:0]  RESET_PC = 8'h00
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     mem_req_valid,
    output logic [PC_W-1:0]          mem_req_addr,
    input  logic                     mem_req_ready,
    input  logic                     mem_resp_valid,
    input  logic [INST_W-1:0]        mem_resp_data,
    output logic                     inst_valid,
    output logic [INST_W-1:0]        inst_data,
    output logic [PC_W-1:0]          inst_pc,
    input  logic                     inst_ready,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned      CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    pf_state_e        state;
    pf_state_e        state_nx;
    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  fetch_pc_nx;
    logic [PC_W-1:0]  req_pc;
    logic             accept;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count_after;
    fetch_entry_t     head;
    fetch_entry_t     wentry;

    assign accept      = (state == REQ) && mem_req_ready;
    assign pop         = inst_valid && inst_ready;
    assign push        = (state == WAIT) && mem_resp_valid && !redirect;
    assign count_after = fifo_count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            if (accept) req_pc <= fetch_pc;
        end
    end

    // Redirect overrides every normal transition; an accepted or in-flight fetch is drained.
    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        if (redirect) begin
            fetch_pc_nx = redirect_pc;
            case (state)
                WAIT:    state_nx = mem_resp_valid ? REQ : DRAIN;
                REQ:     state_nx = mem_req_ready  ? DRAIN : REQ;
                DRAIN:   state_nx = mem_resp_valid ? REQ : DRAIN;
                default: state_nx = REQ;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_count < DEPTH_CNT) state_nx = REQ;
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state_nx    = WAIT;
                        fetch_pc_nx = fetch_pc + PC_W'(1);
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) state_nx = (count_after < DEPTH_CNT) ? REQ : IDLE;
                end
                DRAIN: begin
                    if (mem_resp_valid) state_nx = REQ;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign wentry = '{pc: req_pc, inst: mem_resp_data};

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .wdata (wentry),
        .rdata (head),
        .count (fifo_count)
    );

    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = fetch_pc;
    assign inst_valid    = (fifo_count != '0);
    assign inst_data     = head.inst;
    assign inst_pc       = head.pc;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed vector table plus hand-written multi-cycle sequences for if_prefetch.
module tb_if_prefetch;

    logic       clk;
    logic       reset;
    logic       mem_req_valid;
    logic [7:0] mem_req_addr;
    logic       mem_req_ready;
    logic       mem_resp_valid;
    logic [7:0] mem_resp_data;
    logic       inst_valid;
    logic [7:0] inst_data;
    logic [7:0] inst_pc;
    logic       inst_ready;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic [2:0] fifo_count;

    int         total;
    int         bad;
    logic       auto_resp;
    logic [7:0] req_log[$];

    typedef struct {
        logic       rst;
        logic       rdy;
        logic       rv;
        logic [7:0] rd;
        logic       ir;
        logic       redir;
        logic [7:0] rpc;
        logic       e_mrv;
        logic [7:0] e_addr;
        logic       e_iv;
        logic [7:0] e_pc;
        logic [7:0] e_data;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vt[14];

    if_prefetch #(
        .DEPTH    (4),
        .RESET_PC (8'h00)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .fifo_count     (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%b exp=%b", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // One clock; the memory model answers one cycle after acceptance with addr^A5.
    task automatic cyc();
        logic       acc;
        logic [7:0] a;
        acc = mem_req_valid && mem_req_ready && !reset;
        a   = mem_req_addr;
        @(posedge clk);
        #1;
        if (acc) req_log.push_back(a);
        mem_resp_valid = acc && auto_resp;
        mem_resp_data  = a ^ 8'hA5;
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 8'h00;
        inst_ready     = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 8'h00;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        logic       found;
        logic [7:0] exp_pc;
        logic [7:0] exp_e[4];
        int         idx;

        total     = 0;
        bad       = 0;
        auto_resp = 1'b0;

        //          rst   rdy   rv    rd     ir    redir rpc    | mrv  addr   iv    pc     data   cnt
        vt[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 3'd0};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 3'd0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 8'h00, 8'h00, 3'd0};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h00, 8'hA5, 3'd1};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h00, 8'hA5, 3'd1};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 8'h00, 8'h00, 3'd0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h01, 8'hA4, 3'd1};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h30, 1'b1, 8'h30, 1'b0, 8'h00, 8'h00, 3'd0};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h31, 1'b0, 8'h00, 8'h00, 3'd0};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 8'h94, 1'b0, 1'b1, 8'h50, 1'b1, 8'h50, 1'b0, 8'h00, 8'h00, 3'd0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h60, 1'b0, 8'h60, 1'b0, 8'h00, 8'h00, 3'd0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h60, 1'b0, 8'h00, 8'h00, 3'd0};
        vt[12] = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b1, 8'h60, 1'b0, 8'h00, 8'h00, 3'd0};
        vt[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 3'd0};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            reset          = vt[i].rst;
            mem_req_ready  = vt[i].rdy;
            mem_resp_valid = vt[i].rv;
            mem_resp_data  = vt[i].rd;
            inst_ready     = vt[i].ir;
            redirect       = vt[i].redir;
            redirect_pc    = vt[i].rpc;
            cyc();
            chk1($sformatf("v%0d.mrv", i), mem_req_valid, vt[i].e_mrv);
            chk8($sformatf("v%0d.addr", i), mem_req_addr, vt[i].e_addr);
            chk1($sformatf("v%0d.iv", i), inst_valid, vt[i].e_iv);
            chk8($sformatf("v%0d.cnt", i), 8'(fifo_count), 8'(vt[i].e_cnt));
            if (vt[i].e_iv) begin
                chk8($sformatf("v%0d.pc", i), inst_pc, vt[i].e_pc);
                chk8($sformatf("v%0d.data", i), inst_data, vt[i].e_data);
            end
        end

        // Streaming: every fetched address appears once, in order.
        do_reset();
        auto_resp     = 1'b1;
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        exp_pc        = 8'h00;
        for (int c = 0; c < 30; c++) begin
            cyc();
            if (inst_valid) begin
                chk8("stream.pc", inst_pc, exp_pc);
                chk8("stream.data", inst_data, exp_pc ^ 8'hA5);
                exp_pc = exp_pc + 8'd1;
            end
        end
        chk1("stream.progress", exp_pc >= 8'd10, 1'b1);

        // Backpressure: queue fills with exactly four fetches, then one pop frees one slot.
        do_reset();
        mem_req_ready = 1'b1;
        req_log.delete();
        repeat (20) cyc();
        chk8("full.nreq", 8'(req_log.size()), 8'd4);
        for (int i = 0; i < 4; i++)
            if (req_log.size() > i) chk8($sformatf("full.addr%0d", i), req_log[i], 8'(i));
        chk8("full.cnt", 8'(fifo_count), 8'd4);
        chk1("full.mrv", mem_req_valid, 1'b0);
        chk8("full.head", inst_pc, 8'h00);
        req_log.delete();
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        repeat (10) cyc();
        chk8("refill.nreq", 8'(req_log.size()), 8'd1);
        if (req_log.size() > 0) chk8("refill.addr", req_log[0], 8'h04);
        chk8("refill.cnt", 8'(fifo_count), 8'd4);
        chk8("refill.head", inst_pc, 8'h01);

        // Stalled request holds address and valid until accepted.
        mem_req_ready = 1'b0;
        inst_ready    = 1'b1;
        found         = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            cyc();
            found = mem_req_valid;
        end
        chk1("stall.seen", found, 1'b1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) cyc();
            chk1($sformatf("stall.mrv%0d", k), mem_req_valid, 1'b1);
            chk8($sformatf("stall.addr%0d", k), mem_req_addr, 8'h05);
        end
        mem_req_ready = 1'b1;
        req_log.delete();
        cyc();
        chk8("stall.nacc", 8'(req_log.size()), 8'd1);
        if (req_log.size() > 0) chk8("stall.accaddr", req_log[0], 8'h05);
        chk1("stall.mrv_after", mem_req_valid, 1'b0);

        // Redirect while waiting on 07; its late response must be dropped.
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            cyc();
            found = mem_req_valid && (mem_req_addr == 8'h07);
        end
        chk1("redir.seen07", found, 1'b1);
        auto_resp = 1'b0;
        cyc();
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        cyc();
        redirect = 1'b0;
        chk1("redir.iv", inst_valid, 1'b0);
        chk8("redir.cnt", 8'(fifo_count), 8'd0);
        chk1("redir.drain_mrv", mem_req_valid, 1'b0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 8'h07 ^ 8'hA5;
        cyc();
        chk8("redir.stale_cnt", 8'(fifo_count), 8'd0);
        chk1("redir.mrv", mem_req_valid, 1'b1);
        chk8("redir.addr", mem_req_addr, 8'h40);
        auto_resp = 1'b1;
        found     = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            cyc();
            found = inst_valid;
        end
        chk1("redir.instseen", found, 1'b1);
        chk8("redir.pc", inst_pc, 8'h40);
        chk8("redir.data", inst_data, 8'hE5);

        // Address wrap past FF.
        redirect    = 1'b1;
        redirect_pc = 8'hFE;
        cyc();
        redirect = 1'b0;
        exp_e[0] = 8'hFE;
        exp_e[1] = 8'hFF;
        exp_e[2] = 8'h00;
        exp_e[3] = 8'h01;
        idx = 0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            cyc();
            if (inst_valid) begin
                chk8($sformatf("wrap.pc%0d", idx), inst_pc, exp_e[idx]);
                chk8($sformatf("wrap.data%0d", idx), inst_data, exp_e[idx] ^ 8'hA5);
                idx++;
            end
        end
        chk8("wrap.count", 8'(idx), 8'd4);

        // Reset mid-WAIT, response arriving afterwards is ignored.
        do_reset();
        auto_resp     = 1'b1;
        mem_req_ready = 1'b1;
        found         = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            cyc();
            found = mem_req_valid;
        end
        chk1("rstw.reqseen", found, 1'b1);
        auto_resp = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        chk1("rstw.mrv", mem_req_valid, 1'b0);
        chk1("rstw.iv", inst_valid, 1'b0);
        reset          = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 8'h5A;
        cyc();
        chk1("rstw.iv2", inst_valid, 1'b0);
        chk8("rstw.cnt", 8'(fifo_count), 8'd0);
        chk1("rstw.mrv2", mem_req_valid, 1'b1);
        chk8("rstw.addr", mem_req_addr, 8'h00);
        auto_resp = 1'b1;
        found     = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            cyc();
            found = inst_valid;
        end
        chk1("rstw.instseen", found, 1'b1);
        chk8("rstw.pc", inst_pc, 8'h00);
        chk8("rstw.data", inst_data, 8'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter: DEPTH, default 4, instruction-queue entries (power of two, 2..8).
REQ-002 Parameter: RESET_PC, default 8'h00, first fetch address after reset.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: mem_req_valid  out  1  fetch request to instruction memory.
REQ-006 Port: mem_req_addr  out  8  fetch address.
REQ-007 Port: mem_req_ready  in  1  memory accepts request this cycle.
REQ-008 Port: mem_resp_valid  in  1  response data valid, arrives 1+ cycles after acceptance.
REQ-009 Port: mem_resp_data  in  8  fetched instruction.
REQ-010 Port: inst_valid  out  1  queue head valid toward IF stage.
REQ-011 Port: inst_data  out  8  queue head instruction.
REQ-012 Port: inst_pc  out  8  address of queue head.
REQ-013 Port: inst_ready  in  1  IF stage consumes head this cycle.
REQ-014 Port: redirect  in  1  discard queue, refetch from redirect_pc.
REQ-015 Port: redirect_pc  in  8  new fetch address.
REQ-016 Port: fifo_count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, DRAIN; at most one outstanding memory request.
REQ-018 IDLE -> REQ when fifo_count + (push this cycle) < DEPTH; else stay IDLE.
REQ-019 REQ: mem_req_valid=1, mem_req_addr=fetch_pc; addr/valid held stable until mem_req_ready; accept -> WAIT, fetch_pc <= fetch_pc+1 (mod 256, 8'hFF wraps to 8'h00).
REQ-020 WAIT: on mem_resp_valid push {pc_of_request, mem_resp_data}; -> REQ if space remains after push, else IDLE.
REQ-021 DRAIN: mem_resp_valid discarded (no push), -> REQ; no request issued while in DRAIN.
REQ-022 Queue: show-ahead; inst_valid = (fifo_count != 0); inst_data/inst_pc combinational from head.
REQ-023 Pop when inst_valid && inst_ready; simultaneous push and pop leaves fifo_count unchanged; pointers wrap modulo DEPTH.
REQ-024 Issue rule guarantees no push when full; mem_resp_valid in IDLE or REQ is ignored.
REQ-025 Redirect priority over push, pop and FSM transitions: queue cleared (fifo_count=0, inst_valid=0 next cycle), fetch_pc <= redirect_pc.
REQ-026 Redirect in WAIT, or in REQ with mem_req_ready=1 same cycle -> DRAIN; else -> REQ with new address next cycle (unaccepted request withdrawn).
REQ-027 Redirect in WAIT coinciding with mem_resp_valid: response discarded, -> REQ.
REQ-028 Redirect in DRAIN: stays DRAIN (pending stale response still discarded), fetch_pc updated.

Reset
REQ-029 reset=1: state=IDLE, fetch_pc=RESET_PC, queue empty, mem_req_valid=0, inst_valid=0, fifo_count=0.
REQ-030 reset overrides redirect and all handshakes; reset mid-WAIT abandons request, late response ignored (IDLE).
REQ-031 First mem_req_valid asserted 2nd cycle after reset deasserts (IDLE->REQ).

Structure
REQ-032 Shared package holds: FSM state enum, PC_W=8, INST_W=8, DEPTH default.
REQ-033 Queue is one sub-module, prefetch_fifo (16-bit entries {pc,inst}, push/pop/clear/count).
REQ-034 Output drives IF stage directly; no combinational path from mem_resp_* to inst_* (registered storage).

Verification
REQ-035 Reset, mem_req_ready=1, response 1 cycle after accept, data=addr^8'hA5, inst_ready=1 -> inst_pc 00,01,02... with matching data, no gaps or duplicates.
REQ-036 inst_ready=0 -> exactly DEPTH=4 requests (00..03) issued, fifo_count=4, mem_req_valid=0; one pop -> single request addr 04.
REQ-037 mem_req_ready low 3 cycles -> mem_req_valid/mem_req_addr=05 stable throughout; accepted on 4th cycle.
REQ-038 redirect to 8'h40 in WAIT at addr 07 -> queue empties, response for 07 dropped, next request addr 40, next inst_pc=40.
REQ-039 redirect_pc=8'hFE, consume freely -> inst_pc FE, FF, 00, 01 (wrap).
REQ-040 reset asserted in WAIT, response arrives next cycle -> no push, inst_valid=0, first request addr RESET_PC.
